systolic_gemm_engine: RTL and testbench

//   Parametrised output-stationary systolic GEMM engine: C[R][C] (+)= A[R][K] * B[K][C].

---
 rtl/systolic_gemm_engine_pkg.sv | 23 ++
 rtl/systolic_gemm_engine_if.sv | 41 ++++
 rtl/systolic_gemm_engine_pe.sv | 52 +++++
 rtl/systolic_gemm_engine.sv | 198 +++++++++++++++++++
 tb/tb_systolic_gemm_engine.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_gemm_engine_pkg.sv
// Shared types and default sizes for the systolic GEMM engine.
// Holds the control FSM state encoding and a small width helper.
package systolic_gemm_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int DEF_N_ROWS = 4;
  localparam int DEF_N_COLS = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_K_MAX  = 256;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/systolic_gemm_engine_if.sv
// Control, operand-stream and result-stream signals of the GEMM engine.
// master = tile loader / writeback side, slave = the engine.
interface systolic_gemm_engine_if
  import systolic_gemm_engine_pkg::*;
#(
  parameter int N_ROWS = DEF_N_ROWS,
  parameter int N_COLS = DEF_N_COLS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K_MAX  = DEF_K_MAX
) ();

  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = clog2_min1(N_ROWS);

  logic                     start;
  logic                     acc_en;
  logic [KW-1:0]            k_len;
  logic                     busy;
  logic                     done;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_ROWS*DATA_W-1:0] a_in;
  logic [N_COLS*DATA_W-1:0] b_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_COLS*ACC_W-1:0]  c_out;
  logic [RW-1:0]            out_row;
  logic                     out_last;

  modport master (
    output start, acc_en, k_len, in_valid, a_in, b_in, out_ready,
    input  busy, done, in_ready, out_valid, c_out, out_row, out_last
  );

  modport slave (
    input  start, acc_en, k_len, in_valid, a_in, b_in, out_ready,
    output busy, done, in_ready, out_valid, c_out, out_row, out_last
  );

endinterface

// File: rtl/systolic_gemm_engine_pe.sv
// One output-stationary MAC cell: registers its a/b operands, forwards them
// right/down, and accumulates their full-precision product.
module systolic_gemm_engine_pe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mac_en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc_out
);

  logic signed [DATA_W-1:0]   a_q, a_d;
  logic signed [DATA_W-1:0]   b_q, b_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod;

  always_comb begin
    a_d   = a_in;
    b_d   = b_in;
    prod  = a_q * b_q;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (mac_en) begin
      // Sign-extend the product; the sum wraps modulo 2^ACC_W.
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign acc_out = acc_q;

endmodule

// File: rtl/systolic_gemm_engine.sv
// Output-stationary systolic GEMM engine: streams A columns / B rows in,
// skews them across an N_ROWS x N_COLS PE array, then drains C row by row.
module systolic_gemm_engine
  import systolic_gemm_engine_pkg::*;
#(
  parameter int N_ROWS = DEF_N_ROWS,
  parameter int N_COLS = DEF_N_COLS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K_MAX  = DEF_K_MAX
) (
  input logic clk,
  input logic rst,
  systolic_gemm_engine_if.slave bus
);

  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = clog2_min1(N_ROWS);
  localparam int FW = $clog2(N_ROWS + N_COLS + 1);

  state_t        state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [RW-1:0] row_q, row_d;
  logic          done_q, done_d;

  logic hs_in, mac_en, clr;

  assign hs_in  = (state_q == ST_LOAD) && bus.in_valid;
  assign mac_en = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign clr    = (state_q == ST_IDLE) && bus.start && !bus.acc_en;

  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          k_len_d = bus.k_len;
          beat_d  = '0;
          flush_d = '0;
          row_d   = '0;
          state_d = (bus.k_len == '0) ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (hs_in) begin
          beat_d = beat_q + KW'(1);
          if (beat_q + KW'(1) == k_len_q) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Long enough for the last beat to cross the skew and reach PE(R-1,C-1).
        flush_d = flush_q + FW'(1);
        if (flush_q == FW'(N_ROWS + N_COLS - 1)) begin
          flush_d = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.out_ready) begin
          if (row_q == RW'(N_ROWS - 1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_len_q <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  logic signed [DATA_W-1:0] a_inj  [N_ROWS];
  logic signed [DATA_W-1:0] a_edge [N_ROWS];
  logic signed [DATA_W-1:0] b_inj  [N_COLS];
  logic signed [DATA_W-1:0] b_edge [N_COLS];

  genvar gi, gj;

  // Row i of A is delayed i cycles; bubbles inject zeros.
  for (gi = 0; gi < N_ROWS; gi++) begin : g_skew_a
    assign a_inj[gi] = hs_in ? signed'(bus.a_in[gi*DATA_W +: DATA_W]) : '0;
    if (gi == 0) begin : g_direct
      assign a_edge[gi] = a_inj[gi];
    end else begin : g_delay
      logic signed [DATA_W-1:0] sr_q [gi];
      logic signed [DATA_W-1:0] sr_d [gi];
      always_comb begin
        sr_d[0] = a_inj[gi];
        for (int s = 1; s < gi; s++) sr_d[s] = sr_q[s-1];
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < gi; s++) sr_q[s] <= '0;
        end else begin
          sr_q <= sr_d;
        end
      end
      assign a_edge[gi] = sr_q[gi-1];
    end
  end

  for (gi = 0; gi < N_COLS; gi++) begin : g_skew_b
    assign b_inj[gi] = hs_in ? signed'(bus.b_in[gi*DATA_W +: DATA_W]) : '0;
    if (gi == 0) begin : g_direct
      assign b_edge[gi] = b_inj[gi];
    end else begin : g_delay
      logic signed [DATA_W-1:0] sr_q [gi];
      logic signed [DATA_W-1:0] sr_d [gi];
      always_comb begin
        sr_d[0] = b_inj[gi];
        for (int s = 1; s < gi; s++) sr_d[s] = sr_q[s-1];
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < gi; s++) sr_q[s] <= '0;
        end else begin
          sr_q <= sr_d;
        end
      end
      assign b_edge[gi] = sr_q[gi-1];
    end
  end

  logic signed [DATA_W-1:0] a_bus [N_ROWS][N_COLS+1];
  logic signed [DATA_W-1:0] b_bus [N_ROWS+1][N_COLS];
  logic signed [ACC_W-1:0]  acc   [N_ROWS][N_COLS];

  for (gi = 0; gi < N_ROWS; gi++) begin : g_a_edge
    assign a_bus[gi][0] = a_edge[gi];
  end
  for (gi = 0; gi < N_COLS; gi++) begin : g_b_edge
    assign b_bus[0][gi] = b_edge[gi];
  end

  for (gi = 0; gi < N_ROWS; gi++) begin : g_row
    for (gj = 0; gj < N_COLS; gj++) begin : g_col
      systolic_gemm_engine_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .mac_en  (mac_en),
        .clr     (clr),
        .a_in    (a_bus[gi][gj]),
        .b_in    (b_bus[gi][gj]),
        .a_out   (a_bus[gi][gj+1]),
        .b_out   (b_bus[gi+1][gj]),
        .acc_out (acc[gi][gj])
      );
    end
  end

  logic [N_COLS*ACC_W-1:0] c_row;

  // Accumulators are frozen in DRAIN, so the muxed row is stable under backpressure.
  always_comb begin
    c_row = '0;
    if (state_q == ST_DRAIN) begin
      for (int j = 0; j < N_COLS; j++) c_row[j*ACC_W +: ACC_W] = acc[row_q][j];
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_valid = (state_q == ST_DRAIN);
  assign bus.out_last  = (state_q == ST_DRAIN) && (row_q == RW'(N_ROWS - 1));
  assign bus.out_row   = row_q;
  assign bus.c_out     = c_row;

endmodule

// File: tb/tb_systolic_gemm_engine.sv
// Randomised self-checking bench: a plain matrix-product model predicts every
// C row, plus handshake timing, backpressure, wrap, reset abort and a 2x3 instance.
module tb_systolic_gemm_engine;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int KM = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_gemm_engine_if #(.N_ROWS(R), .N_COLS(C), .DATA_W(DW), .ACC_W(AW), .K_MAX(KM)) ifc ();
  systolic_gemm_engine #(.N_ROWS(R), .N_COLS(C), .DATA_W(DW), .ACC_W(AW), .K_MAX(KM)) dut (
    .clk (clk), .rst (rst), .bus (ifc)
  );

  systolic_gemm_engine_if #(.N_ROWS(2), .N_COLS(3), .DATA_W(DW), .ACC_W(AW), .K_MAX(KM)) ifc2 ();
  systolic_gemm_engine #(.N_ROWS(2), .N_COLS(3), .DATA_W(DW), .ACC_W(AW), .K_MAX(KM)) dut2 (
    .clk (clk), .rst (rst), .bus (ifc2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int a_m   [R][KM];
  int b_m   [KM][C];
  int acc_m [R][C];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d (0x%08h) exp=%0d (0x%08h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) acc_m[i][j] = 0;
  endtask

  // mode 0: A = 1..R*k row-major, B = identity; 1: constants; 2: random signed.
  task automatic fill(input int mode, input int k, input int av, input int bv);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < R; i++)
        a_m[i][kk] = (mode == 0) ? i*k + kk + 1 : (mode == 1) ? av : int'($urandom_range(0, 65535)) - 32768;
      for (int j = 0; j < C; j++)
        b_m[kk][j] = (mode == 0) ? ((kk == j) ? 1 : 0) : (mode == 1) ? bv : int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  task automatic run_pass(input int k, input bit acc_en_i, input bit bubbles, input bit rand_ready,
                          input int stall_row, input bit hold_start);
    int  idx, cyc, lat, load_cyc, row, stall_left, budget, exp_lat;
    bit  v, hs, rdy, stalled;
    @(negedge clk);
    ifc.start  = 1'b1;
    ifc.acc_en = acc_en_i;
    ifc.k_len  = 9'(k);
    if (!acc_en_i) clear_model();
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    ifc.start  = hold_start;
    ifc.acc_en = 1'b0;
    idx = 0; cyc = 0; load_cyc = 0;
    while (idx < k && cyc < 4*k + 10) begin
      if (ifc.in_ready) load_cyc++;
      v = bubbles ? (cyc % 2 == 1) : 1'b1;
      for (int i = 0; i < R; i++) ifc.a_in[i*DW +: DW] = v ? 16'(a_m[i][idx]) : 16'($urandom);
      for (int j = 0; j < C; j++) ifc.b_in[j*DW +: DW] = v ? 16'(b_m[idx][j]) : 16'($urandom);
      ifc.in_valid = v;
      hs = v && ifc.in_ready;
      @(posedge clk);
      lat++;
      if (hs) begin
        for (int i = 0; i < R; i++)
          for (int j = 0; j < C; j++) acc_m[i][j] += a_m[i][idx] * b_m[idx][j];
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    ifc.in_valid = 1'b0;
    ifc.start    = 1'b0;
    if (k > 0) begin
      chk("beats_accepted", 32'(idx), 32'(k));
      chk("load_cycles", 32'(load_cyc), 32'(bubbles ? 2*k : k));
    end
    budget = 0;
    while (!ifc.out_valid && budget < 500) begin
      @(posedge clk);
      lat++;
      budget++;
      @(negedge clk);
    end
    if (!ifc.out_valid) begin
      chk("out_valid_timeout", 32'(ifc.out_valid), 32'd1);
      return;
    end
    if (k > 0) begin
      exp_lat = 1 + (bubbles ? 2*k : k) + R + C;
      chk("latency", 32'(lat), 32'(exp_lat));
    end
    row = 0; stall_left = 0; stalled = 1'b0; budget = 0;
    while (row < R && budget < 200) begin
      if (row == stall_row && !stalled) begin
        stalled    = 1'b1;
        stall_left = 5;
      end
      rdy = (stall_left > 0) ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      ifc.out_ready = rdy;
      chk("out_valid", 32'(ifc.out_valid), 32'd1);
      chk("out_row", 32'(ifc.out_row), 32'(row));
      chk("out_last", 32'(ifc.out_last), 32'(row == R-1));
      chk("done_in_drain", 32'(ifc.done), 32'd0);
      for (int j = 0; j < C; j++)
        chk($sformatf("c[%0d][%0d]", row, j), ifc.c_out[j*AW +: AW], 32'(acc_m[row][j]));
      @(posedge clk);
      if (rdy) begin
        $display("row %0d k=%0d: %0d %0d %0d %0d", row, k,
                 acc_m[row][0], acc_m[row][1], acc_m[row][2], acc_m[row][3]);
        row++;
      end
      if (stall_left > 0) stall_left--;
      budget++;
      @(negedge clk);
    end
    chk("rows_delivered", 32'(row), 32'(R));
    ifc.out_ready = 1'b1;
    chk("done_pulse", 32'(ifc.done), 32'd1);
    chk("busy_after", 32'(ifc.busy), 32'd0);
    @(negedge clk);
    chk("done_width", 32'(ifc.done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.start = 1'b0; ifc.acc_en = 1'b0; ifc.k_len = '0; ifc.in_valid = 1'b0;
    ifc.a_in = '0; ifc.b_in = '0; ifc.out_ready = 1'b1;
    ifc2.start = 1'b0; ifc2.acc_en = 1'b0; ifc2.k_len = '0; ifc2.in_valid = 1'b0;
    ifc2.a_in = '0; ifc2.b_in = '0; ifc2.out_ready = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_out_last", 32'(ifc.out_last), 32'd0);
    chk("rst_c_out", 32'(|ifc.c_out), 32'd0);
    chk("rst_out_row", 32'(ifc.out_row), 32'd0);
    rst = 1'b0;

    // Identity product, then the same tile accumulated (start held high in LOAD is ignored).
    fill(0, 4, 0, 0);
    run_pass(4, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    run_pass(4, 1'b1, 1'b0, 1'b0, -1, 1'b1);
    // Alternating bubbles with garbage data on idle beats.
    fill(1, 4, 2, 3);
    run_pass(4, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    // Backpressure: five stalled cycles while row 1 is presented.
    fill(2, 6, 0, 0);
    run_pass(6, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    // Two's-complement wrap, then a single-beat negative product.
    fill(1, 2, -32768, -32768);
    run_pass(2, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    fill(1, 1, -3, 5);
    run_pass(1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    // Random tiles, random accumulate/bubble/backpressure choices.
    for (int p = 0; p < 6; p++) begin
      int kk;
      kk = int'($urandom_range(1, 20));
      fill(2, kk, 0, 0);
      run_pass(kk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, -1, 1'b0);
    end

    // Reset in the middle of LOAD aborts the pass and clears the accumulators.
    @(negedge clk);
    ifc.start = 1'b1; ifc.acc_en = 1'b1; ifc.k_len = 9'd8;
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0; ifc.in_valid = 1'b1;
    ifc.a_in = {4{16'sd7}}; ifc.b_in = {4{16'sd9}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_load_before_rst", 32'(ifc.in_ready), 32'd1);
    rst = 1'b1; ifc.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(ifc.busy), 32'd0);
    chk("abort_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("abort_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("abort_done", 32'(ifc.done), 32'd0);
    chk("abort_c_out", 32'(|ifc.c_out), 32'd0);
    chk("abort_out_row", 32'(ifc.out_row), 32'd0);
    rst = 1'b0;
    clear_model();
    fill(2, 5, 0, 0);
    run_pass(5, 1'b1, 1'b0, 1'b0, -1, 1'b0);

    // 2x3 instance, empty reduction: two zero rows then done.
    @(negedge clk);
    ifc2.start = 1'b1; ifc2.acc_en = 1'b0; ifc2.k_len = '0;
    @(posedge clk);
    @(negedge clk);
    ifc2.start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      chk("s_out_valid", 32'(ifc2.out_valid), 32'd1);
      chk("s_out_row", 32'(ifc2.out_row), 32'(r));
      chk("s_out_last", 32'(ifc2.out_last), 32'(r == 1));
      chk("s_c_out", 32'(|ifc2.c_out), 32'd0);
      $display("small row %0d: 0 0 0", r);
      @(posedge clk);
      @(negedge clk);
    end
    chk("s_done", 32'(ifc2.done), 32'd1);
    chk("s_busy", 32'(ifc2.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
